// File: rtl/ps2_bk_keyboard_if.sv
// ============================================================================
// Module      : ps2_bk_keyboard_if
// Description : PS/2 line inputs, CPU read strobe and keyboard register
//               outputs of the BK keyboard stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_bk_keyboard_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       read_kbd;
    logic       kbd_available;
    logic [7:0] kbd_data;
    logic       kbd_ar2;
    logic       stopkey;
    logic       keydown;
    logic       kbd_overflow;

    modport slave (
        input  ps2_clk, ps2_dat, read_kbd,
        output kbd_available, kbd_data, kbd_ar2, stopkey, keydown, kbd_overflow
    );

    modport master (
        output ps2_clk, ps2_dat, read_kbd,
        input  kbd_available, kbd_data, kbd_ar2, stopkey, keydown, kbd_overflow
    );
endinterface

`default_nettype wire

// File: rtl/ps2_bk_keyboard.sv
// ============================================================================
// Module      : ps2_bk_keyboard
// Description : PS/2 receiver, E0/F0 prefix decoder and scancode-to-BK
//               translator with a key buffer read through 0177662.
//               KBD_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of the
//               single-entry latch. Translation table is a built-in ROM
//               indexed by {ext, shift, scancode}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_bk_keyboard #(
    parameter int FILTER      = 8,
    parameter int TIMEOUT_CYC = 20000
`ifdef KBD_FIFO_EN
    ,parameter int FIFO_DEPTH = 4
`endif
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    ps2_bk_keyboard_if.slave  kb
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] c_filt_last = FW'(FILTER - 1);
    localparam logic [TW-1:0] c_tmo_last  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXT = 2'd1, S_BRK = 2'd2, S_EXTBRK = 2'd3} state_t;

    logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_q, byte_d;
    state_t        state_q, state_d;
    logic          lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d;
    logic          ar2_q, ar2_d, stop_q, stop_d, keydown_q, keydown_d;
    logic [8:0]    last_key_q, last_key_d;
    logic          rd_q, rd_d, ovf_q, ovf_d;
    logic          is_make, is_break, ext, push, pop, avail;
    logic [7:0]    key_code, push_data, head;

    function automatic logic [7:0] xlat(input logic [9:0] idx);
        logic [7:0] r, letter;
        r = 8'h00;
        letter = 8'h00;
        if (idx[9]) begin
            case (idx[7:0])
                8'h6B: r = 8'h08;  8'h74: r = 8'h19;  8'h75: r = 8'h1A;
                8'h72: r = 8'h1B;  8'h5A: r = 8'h0A;  default: r = 8'h00;
            endcase
        end else begin
            case (idx[7:0])
                8'h1C: letter = 8'h41; 8'h32: letter = 8'h42; 8'h21: letter = 8'h43; 8'h23: letter = 8'h44;
                8'h24: letter = 8'h45; 8'h2B: letter = 8'h46; 8'h34: letter = 8'h47; 8'h33: letter = 8'h48;
                8'h43: letter = 8'h49; 8'h3B: letter = 8'h4A; 8'h42: letter = 8'h4B; 8'h4B: letter = 8'h4C;
                8'h3A: letter = 8'h4D; 8'h31: letter = 8'h4E; 8'h44: letter = 8'h4F; 8'h4D: letter = 8'h50;
                8'h15: letter = 8'h51; 8'h2D: letter = 8'h52; 8'h1B: letter = 8'h53; 8'h2C: letter = 8'h54;
                8'h3C: letter = 8'h55; 8'h2A: letter = 8'h56; 8'h1D: letter = 8'h57; 8'h22: letter = 8'h58;
                8'h35: letter = 8'h59; 8'h1A: letter = 8'h5A; default: letter = 8'h00;
            endcase
            // Shift selects lower-case Latin; digits and controls ignore it.
            if (letter != 8'h00) begin
                r = idx[8] ? (letter | 8'h20) : letter;
            end else begin
                case (idx[7:0])
                    8'h45: r = 8'h30; 8'h16: r = 8'h31; 8'h1E: r = 8'h32; 8'h26: r = 8'h33; 8'h25: r = 8'h34;
                    8'h2E: r = 8'h35; 8'h36: r = 8'h36; 8'h3D: r = 8'h37; 8'h3E: r = 8'h38; 8'h46: r = 8'h39;
                    8'h29: r = 8'h20; 8'h5A: r = 8'h0A; 8'h66: r = 8'h18; default: r = 8'h00;
                endcase
            end
        end
        return r;
    endfunction

    always_comb begin
        clk_sync_d   = {clk_sync_q[0], kb.ps2_clk};
        dat_sync_d   = {dat_sync_q[0], kb.ps2_dat};
        filt_d       = filt_q;
        filt_cnt_d   = '0;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        tmo_d        = '0;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == c_filt_last) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        if (filt_q && !filt_d) begin
            if (bitcnt_q == 4'd10) begin
                // shift_q = {parity, data[7:0], start}; current sample is the stop bit.
                byte_valid_d = !shift_q[0] && (^shift_q[9:1]) && dat_sync_q[1];
                byte_d       = shift_q[8:1];
                bitcnt_d     = 4'd0;
            end else begin
                shift_d  = {dat_sync_q[1], shift_q[9:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (tmo_q == c_tmo_last) begin
                bitcnt_d = 4'd0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        is_make    = 1'b0;
        is_break   = 1'b0;
        ext        = 1'b0;
        lshift_d   = lshift_q;
        rshift_d   = rshift_q;
        ctrl_d     = ctrl_q;
        ar2_d      = ar2_q;
        stop_d     = stop_q;
        keydown_d  = keydown_q;
        last_key_d = last_key_q;
        push       = 1'b0;
        rd_d       = kb.read_kbd;
        pop        = rd_q && !kb.read_kbd;
        if (byte_valid_q) begin
            if (byte_q == 8'hE1 || byte_q == 8'hAA) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:   if (byte_q == 8'hE0) state_d = S_EXT;
                              else if (byte_q == 8'hF0) state_d = S_BRK;
                              else is_make = 1'b1;
                    S_EXT:    if (byte_q == 8'hF0) state_d = S_EXTBRK;
                              else begin is_make = 1'b1; ext = 1'b1; state_d = S_IDLE; end
                    S_BRK:    begin is_break = 1'b1; state_d = S_IDLE; end
                    S_EXTBRK: begin is_break = 1'b1; ext = 1'b1; state_d = S_IDLE; end
                    default:  state_d = S_IDLE;
                endcase
            end
        end
        key_code = xlat({ext, lshift_q | rshift_q, byte_q});
        if (ctrl_q && key_code[7:6] == 2'b01) key_code = {3'b000, key_code[4:0]};
        push_data = {ar2_q, key_code[6:0]};
        if (is_make || is_break) begin
            if (byte_q == 8'h12)                lshift_d = is_make;
            else if (byte_q == 8'h59)           rshift_d = is_make;
            else if (byte_q == 8'h14)           ctrl_d   = is_make;
            else if (byte_q == 8'h11 && !ext)   ar2_d    = is_make;
            else if (byte_q == 8'h07)           stop_d   = is_make;
            else if (is_make) begin
                if (key_code != 8'h00) begin
                    push       = 1'b1;
                    last_key_d = {ext, byte_q};
                    keydown_d  = 1'b1;
                end
            end else if ({ext, byte_q} == last_key_q) begin
                keydown_d = 1'b0;
            end
        end
    end

`ifdef KBD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rp_q, rp_d;
    logic        empty, full, do_pop;

    assign empty  = (wr_q == rp_q);
    assign full   = (wr_q[AW] != rp_q[AW]) && (wr_q[AW-1:0] == rp_q[AW-1:0]);
    assign do_pop = pop && !empty;
    assign avail  = !empty;
    assign head   = mem_q[rp_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rp_d  = rp_q;
        ovf_d = 1'b0;
        if (do_pop) rp_d = rp_q + 1'b1;
        if (push) begin
            if (!full || do_pop) begin
                mem_d[wr_q[AW-1:0]] = push_data;
                wr_d = wr_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_q <= '0;
            rp_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rp_q  <= rp_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    assign avail = valid_q;
    assign head  = hold_q;

    // Latest key wins; overflow flags only a key that was never read.
    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;
        if (pop) valid_d = 1'b0;
        if (push) begin
            hold_d  = push_data;
            valid_d = 1'b1;
            ovf_d   = valid_q && !pop;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            bitcnt_q     <= 4'd0;
            shift_q      <= 10'd0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            state_q      <= S_IDLE;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            ctrl_q       <= 1'b0;
            ar2_q        <= 1'b0;
            stop_q       <= 1'b0;
            keydown_q    <= 1'b0;
            last_key_q   <= 9'd0;
            rd_q         <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            state_q      <= state_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            ctrl_q       <= ctrl_d;
            ar2_q        <= ar2_d;
            stop_q       <= stop_d;
            keydown_q    <= keydown_d;
            last_key_q   <= last_key_d;
            rd_q         <= rd_d;
            ovf_q        <= ovf_d;
        end
    end

    assign kb.kbd_available = avail;
    assign kb.kbd_data      = {1'b0, head[6:0]};
    assign kb.kbd_ar2       = head[7];
    assign kb.stopkey       = stop_q;
    assign kb.keydown       = keydown_q;
    assign kb.kbd_overflow  = ovf_q;

endmodule

`default_nettype wire
